// File: rtl/ro_trace_capture_pkg.sv
// Shared types and default sizes for the ring-oscillator trace capture block.
// No logic; constants and the controller state encoding only.
// No flow control here.
package ro_trace_capture_pkg;

    localparam int RO_RESULT_WIDTH     = 19;
    localparam int RO_NUM_SAMPLE_WIDTH = 3;
    localparam int RO_DEPTH            = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN
    } ro_state_t;

endpackage

// File: rtl/ro_trace_capture_if.sv
// Trace read stream toward the host readout path.
// Pure wiring, zero latency.
// Standard valid/ready: a word transfers when rd_valid & rd_ready.
interface ro_trace_capture_if
    import ro_trace_capture_pkg::*;
#(
    parameter int RESULT_WIDTH = RO_RESULT_WIDTH
);
    logic [RESULT_WIDTH-1:0] rd_data;
    logic                    rd_valid;
    logic                    rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/ro_trace_capture_ram.sv
// Simple dual-port trace buffer: one write port, one registered read port.
// Read data valid one cycle after re.
// No backpressure; caller owns read scheduling.
module ro_trace_capture_ram #(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 19,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ro_trace_capture.sv
// Drives ro_top, captures add-tree results into a trace RAM, then streams them out.
// First word 2 cycles after entering DRAIN, then one word per cycle.
// rd_ready low holds rd_data/rd_valid; a skid register absorbs the in-flight RAM read.
module ro_trace_capture
    import ro_trace_capture_pkg::*;
#(
    parameter int  RESULT_WIDTH     = RO_RESULT_WIDTH,
    parameter int  NUM_SAMPLE_WIDTH = RO_NUM_SAMPLE_WIDTH,
    parameter int  DEPTH            = RO_DEPTH,
    localparam int ADDR_WIDTH       = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH:0]         capture_len,
    input  logic [NUM_SAMPLE_WIDTH-1:0] cfg_num_samples,
    output logic                        ro_go,
    output logic [NUM_SAMPLE_WIDTH-1:0] ro_num_samples,
    input  logic [RESULT_WIDTH-1:0]     add_tree_result,
    input  logic                        add_tree_valid_out,
    ro_trace_capture_if.master          rd,
    output logic                        busy,
    output logic                        done,
    output logic                        dropped
);
    localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    ro_state_t               state;
    logic [ADDR_WIDTH:0]     len;
    logic [ADDR_WIDTH:0]     wr_cnt;
    logic [ADDR_WIDTH:0]     rd_cnt;
    logic [ADDR_WIDTH:0]     hs_cnt;
    logic [ADDR_WIDTH:0]     wr_cnt_nxt;
    logic [ADDR_WIDTH:0]     hs_cnt_nxt;
    logic                    rq_vld;
    logic                    sk_vld;
    logic [RESULT_WIDTH-1:0] sk_dat;
    logic [RESULT_WIDTH-1:0] ram_rdata;
    logic                    wr_en;
    logic                    rd_en;
    logic                    pop;
    logic                    load_out;
    logic [1:0]              occ_after;

    always_comb begin
        wr_en      = (state == ST_CAPTURE) && add_tree_valid_out;
        pop        = rd.rd_valid && rd.rd_ready;
        load_out   = !rd.rd_valid || pop;
        wr_cnt_nxt = wr_cnt + CNT_ONE;
        hs_cnt_nxt = hs_cnt + CNT_ONE;
        // Words held after this cycle; a new read may only be issued if the
        // output+skid pair can still take it when it lands next cycle.
        occ_after  = {1'b0, rd.rd_valid} + {1'b0, sk_vld} + {1'b0, rq_vld} - {1'b0, pop};
        rd_en      = (state == ST_DRAIN) && (rd_cnt != len) && (occ_after <= 2'd1);
    end

    ro_trace_capture_ram #(
        .DEPTH      (DEPTH),
        .WIDTH      (RESULT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_cnt[ADDR_WIDTH-1:0]),
        .wdata (add_tree_result),
        .re    (rd_en),
        .raddr (rd_cnt[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            len            <= '0;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            hs_cnt         <= '0;
            ro_go          <= 1'b0;
            ro_num_samples <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            dropped        <= 1'b0;
            rq_vld         <= 1'b0;
            sk_vld         <= 1'b0;
            sk_dat         <= '0;
            rd.rd_valid    <= 1'b0;
            rd.rd_data     <= '0;
        end else begin
            done   <= 1'b0;
            rq_vld <= rd_en;
            if (rd_en) rd_cnt <= rd_cnt + CNT_ONE;
            if (pop)   hs_cnt <= hs_cnt_nxt;

            if (load_out) begin
                if (sk_vld) begin
                    rd.rd_data  <= sk_dat;
                    rd.rd_valid <= 1'b1;
                    sk_vld      <= rq_vld;
                    if (rq_vld) sk_dat <= ram_rdata;
                end else if (rq_vld) begin
                    rd.rd_data  <= ram_rdata;
                    rd.rd_valid <= 1'b1;
                end else begin
                    rd.rd_valid <= 1'b0;
                end
            end else if (rq_vld) begin
                sk_dat <= ram_rdata;
                sk_vld <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len            <= (capture_len > LEN_MAX) ? LEN_MAX : capture_len;
                        ro_num_samples <= cfg_num_samples;
                        dropped        <= 1'b0;
                        wr_cnt         <= '0;
                        rd_cnt         <= '0;
                        hs_cnt         <= '0;
                        if (capture_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_CAPTURE;
                            ro_go <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (add_tree_valid_out) begin
                        wr_cnt <= wr_cnt_nxt;
                        if (wr_cnt_nxt == len) begin
                            ro_go <= 1'b0;
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && hs_cnt_nxt == len) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A result arriving outside CAPTURE has no slot; flag it, sticky until next start.
            if (add_tree_valid_out && state != ST_CAPTURE) dropped <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ro_trace_capture.sv
// Directed bench for ro_trace_capture: capture/drain, stalls, clamp, zero length,
// dropped results and mid-capture reset.
module tb_ro_trace_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  capture_len = '0;
    logic [2:0]  cfg_num_samples = '0;
    logic        ro_go;
    logic [2:0]  ro_num_samples;
    logic [18:0] add_tree_result = '0;
    logic        add_tree_valid_out = 1'b0;
    logic        busy;
    logic        done;
    logic        dropped;

    int vec_cnt = 0;
    int miscompares = 0;

    ro_trace_capture_if #(.RESULT_WIDTH(19)) rd_if ();

    ro_trace_capture #(
        .RESULT_WIDTH     (19),
        .NUM_SAMPLE_WIDTH (3),
        .DEPTH            (64)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .capture_len        (capture_len),
        .cfg_num_samples    (cfg_num_samples),
        .ro_go              (ro_go),
        .ro_num_samples     (ro_num_samples),
        .add_tree_result    (add_tree_result),
        .add_tree_valid_out (add_tree_valid_out),
        .rd                 (rd_if.master),
        .busy               (busy),
        .done               (done),
        .dropped            (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a capture, feed min(len,64) results base, base+1, ..., then drain and check.
    task automatic capture_and_drain(input int len, input int ns, input int base,
                                     input bit rand_ready, input bit junk_in_drain);
        int          exp_n;
        int          got;
        int          first_vld;
        int          last_hs;
        int          done_cnt;
        int          done_at;
        int          bound;
        bit          stall;
        logic [18:0] held;
        exp_n     = (len > 64) ? 64 : len;
        got       = 0;
        first_vld = -1;
        last_hs   = -1;
        done_cnt  = 0;
        done_at   = -1;
        stall     = 1'b0;
        held      = '0;
        bound     = exp_n * 4 + 20;

        start           = 1'b1;
        capture_len     = 7'(len);
        cfg_num_samples = 3'(ns);
        tick();
        start           = 1'b0;
        capture_len     = 7'd3;
        cfg_num_samples = 3'd0;
        chk("busy_capture", busy, 1);
        chk("ro_go_capture", ro_go, 1);
        chk("ro_num_samples", ro_num_samples, ns);
        chk("dropped_cleared", dropped, 0);

        for (int i = 0; i < exp_n; i++) begin
            add_tree_valid_out = 1'b1;
            add_tree_result    = 19'(base + i);
            if (i == exp_n - 1) chk("ro_go_before_last", ro_go, 1);
            tick();
        end
        add_tree_valid_out = 1'b0;
        chk("ro_go_drain", ro_go, 0);
        chk("busy_drain", busy, 1);

        for (int c = 0; c < bound && done_cnt == 0; c++) begin
            rd_if.rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk_in_drain && c == 3) begin
                add_tree_valid_out = 1'b1;
                add_tree_result    = 19'h5A5A5;
            end else begin
                add_tree_valid_out = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (stall) begin
                chk("hold_valid", rd_if.rd_valid, 1);
                chk("hold_data", rd_if.rd_data, held);
            end
            if (rd_if.rd_valid && first_vld < 0) first_vld = c;
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                chk("rd_data", rd_if.rd_data, (base + got) & 32'h7FFFF);
                got++;
                last_hs = c;
            end
            stall = rd_if.rd_valid && !rd_if.rd_ready;
            held  = rd_if.rd_data;
            @(posedge clk);
            #1;
        end
        add_tree_valid_out = 1'b0;
        rd_if.rd_ready     = 1'b0;

        chk("drain_words", got, exp_n);
        chk("done_seen", done_cnt, 1);
        if (!rand_ready) begin
            chk("first_valid_latency", first_vld, 2);
            chk("no_bubbles", last_hs - first_vld + 1, exp_n);
            chk("done_latency", done_at, last_hs + 1);
        end
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("rd_valid_idle", rd_if.rd_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_if.rd_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ro_go", ro_go, 0);
        chk("rst_ro_num_samples", ro_num_samples, 0);
        chk("rst_rd_valid", rd_if.rd_valid, 0);
        chk("rst_rd_data", rd_if.rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dropped", dropped, 0);
        rst = 1'b0;
        tick();

        // 1: basic capture of 8, streaming at full rate
        capture_and_drain(8, 7, 5, 1'b0, 1'b0);
        chk("ns_latched_after", ro_num_samples, 7);
        chk("dropped_clean", dropped, 0);

        // 2: random backpressure during drain
        capture_and_drain(16, 3, 'h40000, 1'b1, 1'b0);

        // 5: stray results in IDLE and DRAIN
        add_tree_valid_out = 1'b1;
        add_tree_result    = 19'h12345;
        tick();
        add_tree_valid_out = 1'b0;
        chk("dropped_idle", dropped, 1);
        chk("busy_after_idle_junk", busy, 0);
        capture_and_drain(4, 1, 'h100, 1'b0, 1'b1);
        chk("dropped_drain", dropped, 1);

        // 3: length clamped to buffer depth (start also clears dropped)
        capture_and_drain(100, 5, 1000, 1'b0, 1'b0);

        // 4: zero length
        start       = 1'b1;
        capture_len = 7'd0;
        tick();
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_ro_go", ro_go, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("len0_done_off", done, 0);
            chk("len0_ro_go_off", ro_go, 0);
        end

        // 6: reset in the middle of a capture
        start           = 1'b1;
        capture_len     = 7'd8;
        cfg_num_samples = 3'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            add_tree_valid_out = 1'b1;
            add_tree_result    = 19'(200 + i);
            tick();
        end
        add_tree_valid_out = 1'b0;
        chk("midcap_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("midrst_ro_go", ro_go, 0);
        chk("midrst_ns", ro_num_samples, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_valid", rd_if.rd_valid, 0);
        chk("midrst_rd_data", rd_if.rd_data, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_done", done, 0);
            chk("midrst_idle", busy, 0);
        end
        capture_and_drain(4, 4, 'h7FFF0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule
